// File: rtl/jump_control_block.sv
// PC redirect control for the 16-bit pipelined MIPS core: jump/return decode,
// branch evaluation, and a single-level interrupt. Optional macro: JCB_INTERRUPT_EN.
module jump_control_block (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] jmp_address_pm,
  input  logic [15:0] current_address,
  input  logic [5:0]  op,
  input  logic [1:0]  flag_ex,
  input  logic        interrupt,
  output logic        pc_mux_sel,
  output logic [15:0] jmp_loc
);

  localparam logic [5:0]  OP_JMP     = 6'b011000;
  localparam logic [5:0]  OP_JC      = 6'b011100;
  localparam logic [5:0]  OP_JNC     = 6'b011101;
  localparam logic [5:0]  OP_JZ      = 6'b011110;
  localparam logic [5:0]  OP_JNZ     = 6'b011111;
  localparam logic [5:0]  OP_RET     = 6'b010000;
  localparam logic [15:0] INT_VECTOR = 16'hF000;

  typedef enum logic [2:0] {
    J_NONE,
    J_JMP,
    J_JC,
    J_JNC,
    J_JZ,
    J_JNZ,
    J_RET
  } jump_e;

  jump_e       w_jump;
  logic [1:0]  w_flags;
  logic        w_cond_taken;
  logic        w_int_accept;
  logic [15:0] w_ret_addr;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_jump = J_NONE;
    case (op)
      OP_JMP:  w_jump = J_JMP;
      OP_JC:   w_jump = J_JC;
      OP_JNC:  w_jump = J_JNC;
      OP_JZ:   w_jump = J_JZ;
      OP_JNZ:  w_jump = J_JNZ;
`ifdef JCB_INTERRUPT_EN
      OP_RET:  w_jump = J_RET;
`endif
      default: w_jump = J_NONE;
    endcase
  end

`ifdef JCB_INTERRUPT_EN
  logic        r_int_d;
  logic        r_in_isr;
  logic [15:0] r_ret_addr;
  logic [1:0]  r_sav_flags;
  logic        r_restore;

  assign w_int_accept = interrupt & ~r_int_d & ~r_in_isr;
  assign w_ret_addr   = r_ret_addr;
  // The first branch after RET sees the flags captured at interrupt entry.
  assign w_flags      = r_restore ? r_sav_flags : flag_ex;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_d     <= 1'b0;
      r_in_isr    <= 1'b0;
      r_ret_addr  <= 16'h0000;
      r_sav_flags <= 2'b00;
      r_restore   <= 1'b0;
    end else begin
      r_int_d   <= interrupt;
      r_restore <= 1'b0;
      if (w_int_accept) begin
        r_ret_addr  <= current_address + 16'd1;
        r_sav_flags <= flag_ex;
        r_in_isr    <= 1'b1;
      end else if (w_jump == J_RET) begin
        r_in_isr  <= 1'b0;
        r_restore <= 1'b1;
      end
    end
  end
`else
  logic w_unused_interrupt;

  assign w_unused_interrupt = interrupt;
  assign w_int_accept       = 1'b0;
  assign w_ret_addr         = 16'h0000;
  assign w_flags            = flag_ex;
`endif

  always_comb begin
    w_cond_taken = 1'b0;
    case (w_jump)
      J_JMP:   w_cond_taken = 1'b1;
      J_JC:    w_cond_taken = w_flags[1];
      J_JNC:   w_cond_taken = ~w_flags[1];
      J_JZ:    w_cond_taken = w_flags[0];
      J_JNZ:   w_cond_taken = ~w_flags[0];
      default: w_cond_taken = 1'b0;
    endcase
  end

  // Priority: accepted interrupt, then RET, then jumps; reset forces zeros.
  always_comb begin
    pc_mux_sel = 1'b0;
    jmp_loc    = jmp_address_pm;
    if (reset) begin
      pc_mux_sel = 1'b0;
      jmp_loc    = 16'h0000;
    end else if (w_int_accept) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = INT_VECTOR;
    end else if (w_jump == J_RET) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = w_ret_addr;
    end else if (w_cond_taken) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = jmp_address_pm;
    end
  end

endmodule

// File: tb/tb_jump_control_block.sv
// Scoreboard bench for jump_control_block: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_jump_control_block;

`ifdef JCB_INTERRUPT_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_JC  = 6'b011100;
  localparam logic [5:0] OP_JNC = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_RET = 6'b010000;

  logic        clk;
  logic        reset;
  logic [15:0] jmp_address_pm;
  logic [15:0] current_address;
  logic [5:0]  op;
  logic [1:0]  flag_ex;
  logic        interrupt;
  logic        pc_mux_sel;
  logic [15:0] jmp_loc;

  typedef struct {
    string       name;
    logic        sel;
    logic [15:0] loc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  jump_control_block dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_address_pm  (jmp_address_pm),
    .current_address (current_address),
    .op              (op),
    .flag_ex         (flag_ex),
    .interrupt       (interrupt),
    .pc_mux_sel      (pc_mux_sel),
    .jmp_loc         (jmp_loc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act_sel, input logic [15:0] act_loc,
                       input logic exp_sel, input logic [15:0] exp_loc);
    n_tests++;
    if (act_sel !== exp_sel || act_loc !== exp_loc) begin
      n_fail++;
      $display("FAIL %s: got sel=%b loc=%h, expected sel=%b loc=%h",
               nm, act_sel, act_loc, exp_sel, exp_loc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, pc_mux_sel, jmp_loc, e.sel, e.loc);
    end
  end

  // Drive one cycle of inputs, queue the expected outputs, advance past the edge.
  task automatic step(input string nm, input logic rst, input logic [5:0] o,
                      input logic [1:0] f, input logic irq, input logic [15:0] cur,
                      input logic [15:0] pm, input logic es, input logic [15:0] el);
    exp_t e;
    reset           = rst;
    op              = o;
    flag_ex         = f;
    interrupt       = irq;
    current_address = cur;
    jmp_address_pm  = pm;
    e.name = nm;
    e.sel  = es;
    e.loc  = el;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  cond_ops[4];
    logic        taken;
    logic [15:0] pm;
    cond_ops[0] = OP_JZ;
    cond_ops[1] = OP_JNZ;
    cond_ops[2] = OP_JC;
    cond_ops[3] = OP_JNC;

    reset = 1'b1; op = OP_NOP; flag_ex = 2'b00; interrupt = 1'b0;
    current_address = 16'h0000; jmp_address_pm = 16'h0000;
    @(posedge clk);
    #1;

    // Reset forces zeros even with a JMP presented
    step("reset_jmp0", 1, OP_JMP, 2'b00, 0, 16'h0000, 16'h0008, 0, 16'h0000);
    step("reset_jmp1", 1, OP_JMP, 2'b00, 0, 16'h0000, 16'h0008, 0, 16'h0000);
    step("post_reset", 0, OP_NOP, 2'b00, 0, 16'h0000, 16'h0008, 0, 16'h0008);

    // Interrupt entry, held two cycles: exactly one accept
    step("int_entry", 0, OP_NOP, 2'b11, 1, 16'h0001, 16'h0008,
         IE, IE ? 16'hF000 : 16'h0008);
    step("int_held",  0, OP_NOP, 2'b11, 1, 16'h0001, 16'h0008, 0, 16'h0008);
    step("jmp",       0, OP_JMP, 2'b11, 0, 16'h0002, 16'h0008, 1, 16'h0008);

    // RET to saved address, then JZ on restored flags (zero=1), then live flags
    step("ret",        0, OP_RET, 2'b00, 0, 16'h0003, 16'h0008,
         IE, IE ? 16'h0002 : 16'h0008);
    step("jz_restore", 0, OP_JZ,  2'b00, 0, 16'h0004, 16'h0008, IE, 16'h0008);
    step("jz_live",    0, OP_JZ,  2'b00, 0, 16'h0005, 16'h0008, 0, 16'h0008);

    // Conditional sweep on live flags: JZ zero=1, JNZ zero=0, JC carry=1, JNC carry=0
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) begin
        pm = 16'h0100 + 16'(f * 4 + k);
        case (k)
          0:       taken = (f == 1) || (f == 3);
          1:       taken = (f == 0) || (f == 2);
          2:       taken = (f == 2) || (f == 3);
          default: taken = (f == 0) || (f == 1);
        endcase
        step($sformatf("cond_op%0d_f%0d", k, f), 0, cond_ops[k], 2'(f), 0,
             16'h0010, pm, taken, pm);
      end
    end
    step("nop_never", 0, OP_NOP,    2'b11, 0, 16'h0010, 16'h0200, 0, 16'h0200);
    step("other_op",  0, 6'b011001, 2'b11, 0, 16'h0010, 16'h0201, 0, 16'h0201);

    // Masking: second edge during ISR is dropped
    step("int2_entry", 0, OP_NOP, 2'b01, 1, 16'h0010, 16'h0300,
         IE, IE ? 16'hF000 : 16'h0300);
    step("int2_low",   0, OP_NOP, 2'b01, 0, 16'h0011, 16'h0301, 0, 16'h0301);
    step("int_masked", 0, OP_NOP, 2'b01, 1, 16'h0012, 16'h0302, 0, 16'h0302);
    step("int3_low",   0, OP_NOP, 2'b01, 0, 16'h0013, 16'h0303, 0, 16'h0303);
    step("ret2",       0, OP_RET, 2'b00, 0, 16'h0014, 16'h0304,
         IE, IE ? 16'h0011 : 16'h0304);
    // Restored zero=1 blocks JNZ; live zero=0 would take it
    step("jnz_restore", 0, OP_JNZ, 2'b00, 0, 16'h0015, 16'h0305, !IE, 16'h0305);

    // Interrupt beats JMP; return address wraps from 16'hFFFF
    step("int_vs_jmp", 0, OP_JMP, 2'b10, 1, 16'hFFFF, 16'h0040,
         1, IE ? 16'hF000 : 16'h0040);
    step("ret_wrap",   0, OP_RET, 2'b00, 0, 16'h0000, 16'h0041,
         IE, IE ? 16'h0000 : 16'h0041);

    // Reset mid-ISR loses the return address
    step("int4_entry", 0, OP_NOP, 2'b10, 1, 16'h0020, 16'h0050,
         IE, IE ? 16'hF000 : 16'h0050);
    step("reset_isr",  1, OP_JMP, 2'b10, 0, 16'h0021, 16'h0051, 0, 16'h0000);
    step("ret_after_rst", 0, OP_RET, 2'b00, 0, 16'h0022, 16'h0052,
         IE, IE ? 16'h0000 : 16'h0052);

    // Interrupt high across reset release is accepted once
    step("reset_irq_hi", 1, OP_NOP, 2'b00, 1, 16'h0030, 16'h0060, 0, 16'h0000);
    step("irq_at_release", 0, OP_NOP, 2'b00, 1, 16'h0030, 16'h0060,
         IE, IE ? 16'hF000 : 16'h0060);
    step("irq_still_hi", 0, OP_NOP, 2'b00, 1, 16'h0031, 16'h0061, 0, 16'h0061);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
